// File: rtl/board_writer.sv
// -----------------------------------------------------------------------------
// board_writer
//
// Board-state writer for a 3x3 tic-tac-toe VGA display. Holds the nine-cell
// board, a row/col selection cursor moved by push buttons, and the X/O turn.
// It detects a win or a draw after every placement. Cell contents are served
// to the renderer through a combinational read port.
//
// Ports
//   clk          in   pixel-domain clock
//   rst_n        in   asynchronous active-low reset
//   btn_right    in   async button, advances cursor column (wraps 2 -> 0)
//   btn_down     in   async button, advances cursor row (wraps 2 -> 0)
//   btn_place    in   async button, places current player's mark at cursor
//   btn_clear    in   async button, starts a new game
//   read_addr    in   renderer cell address 0..8
//   read_data    out  cell contents: 00 empty, 01 X, 10 O (00 for 9..15)
//   cursor_addr  out  cursor cell, row*3 + col
//   cursor_posx  out  cursor sprite origin x = 73 + col*210
//   cursor_posy  out  cursor sprite origin y = 47 + row*158
//   turn         out  0 = X to move, 1 = O to move
//   game_over    out  high once a win or draw is detected
//   winner       out  01 X, 10 O, 00 draw or in progress
//   write_valid  out  one-cycle pulse when a mark is written
//   place_err    out  one-cycle pulse when placing on an occupied cell
// -----------------------------------------------------------------------------
module board_writer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_place,
    input  logic       btn_clear,
    input  logic [3:0] read_addr,
    output logic [1:0] read_data,
    output logic [3:0] cursor_addr,
    output logic [9:0] cursor_posx,
    output logic [9:0] cursor_posy,
    output logic       turn,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       write_valid,
    output logic       place_err
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    localparam logic [1:0] MARK_NONE = 2'b00;
    localparam logic [1:0] MARK_X    = 2'b01;
    localparam logic [1:0] MARK_O    = 2'b10;

    // Button bit order used throughout: {clear, place, down, right}.
    logic [3:0] btn_raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] prev_q;
    logic [3:0] rise;

    logic       rise_right;
    logic       rise_down;
    logic       rise_place;
    logic       rise_clear;

    state_e     state_q;
    logic [1:0] board_q [9];
    logic [1:0] row_q;
    logic [1:0] col_q;
    logic [1:0] row_d;
    logic [1:0] col_d;
    logic       turn_q;
    logic       game_over_q;
    logic [1:0] winner_q;
    logic       write_valid_q;
    logic       place_err_q;

    logic [1:0] win_mark;
    logic       board_full;
    logic       cursor_empty;
    logic [1:0] place_mark;

    assign btn_raw    = {btn_clear, btn_place, btn_down, btn_right};
    assign rise       = sync2_q & ~prev_q;
    assign rise_right = rise[0];
    assign rise_down  = rise[1];
    assign rise_place = rise[2];
    assign rise_clear = rise[3];

    // ------------------------------------------------------------------
    // Cursor geometry
    // ------------------------------------------------------------------
    assign cursor_addr = ({2'b00, row_q} * 4'd3) + {2'b00, col_q};

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cursor_posx = 10'd73;
        cursor_posy = 10'd47;
        case (col_q)
            2'd0:    cursor_posx = 10'd73;
            2'd1:    cursor_posx = 10'd283;
            default: cursor_posx = 10'd493;
        endcase
        case (row_q)
            2'd0:    cursor_posy = 10'd47;
            2'd1:    cursor_posy = 10'd205;
            default: cursor_posy = 10'd363;
        endcase
    end

    // Next cursor position from move edges; right and down compose freely.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (rise_right) col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        if (rise_down)  row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
    end

    // ------------------------------------------------------------------
    // Board evaluation
    // ------------------------------------------------------------------
    function automatic logic [1:0] line_mark(input logic [1:0] a,
                                             input logic [1:0] b,
                                             input logic [1:0] c);
        return (a != MARK_NONE && a == b && b == c) ? a : MARK_NONE;
    endfunction

    // Checked after every placement, so at most one player can own a line
    // and OR-ing the eight results yields that player's mark.
    always_comb begin
        win_mark = line_mark(board_q[0], board_q[1], board_q[2])
                 | line_mark(board_q[3], board_q[4], board_q[5])
                 | line_mark(board_q[6], board_q[7], board_q[8])
                 | line_mark(board_q[0], board_q[3], board_q[6])
                 | line_mark(board_q[1], board_q[4], board_q[7])
                 | line_mark(board_q[2], board_q[5], board_q[8])
                 | line_mark(board_q[0], board_q[4], board_q[8])
                 | line_mark(board_q[2], board_q[4], board_q[6]);
    end

    always_comb begin
        board_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (board_q[i] == MARK_NONE) board_full = 1'b0;
        end
    end

    assign cursor_empty = (board_q[cursor_addr] == MARK_NONE);
    assign place_mark   = turn_q ? MARK_O : MARK_X;

    // Renderer read port; addresses past the board read as empty.
    assign read_data = (read_addr < 4'd9) ? board_q[read_addr] : MARK_NONE;

    // ------------------------------------------------------------------
    // Synchronizers, edge detect and game FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            state_q       <= ST_PLAY;
            // NOTE: the board is a nine-entry register file, not a RAM, and
            // must read empty straight out of reset, so it is reset here.
            for (int i = 0; i < 9; i++) board_q[i] <= MARK_NONE;
            row_q         <= 2'd0;
            col_q         <= 2'd0;
            turn_q        <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= MARK_NONE;
            write_valid_q <= 1'b0;
            place_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others (the 2-flop chain relies on it).
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            write_valid_q <= 1'b0;
            place_err_q   <= 1'b0;

            if (rise_clear) begin
                for (int i = 0; i < 9; i++) board_q[i] <= MARK_NONE;
                row_q       <= 2'd0;
                col_q       <= 2'd0;
                turn_q      <= 1'b0;
                game_over_q <= 1'b0;
                winner_q    <= MARK_NONE;
                state_q     <= ST_PLAY;
            end else begin
                case (state_q)
                    ST_PLAY: begin
                        // A place edge wins over moves in the same cycle and
                        // uses the cursor as it was before those moves.
                        if (rise_place) begin
                            if (cursor_empty) begin
                                board_q[cursor_addr] <= place_mark;
                                write_valid_q        <= 1'b1;
                                state_q              <= ST_CHECK;
                            end else begin
                                place_err_q <= 1'b1;
                            end
                        end else begin
                            row_q <= row_d;
                            col_q <= col_d;
                        end
                    end
                    ST_CHECK: begin
                        if (win_mark != MARK_NONE) begin
                            winner_q    <= win_mark;
                            game_over_q <= 1'b1;
                            state_q     <= ST_OVER;
                        end else if (board_full) begin
                            winner_q    <= MARK_NONE;
                            game_over_q <= 1'b1;
                            state_q     <= ST_OVER;
                        end else begin
                            turn_q  <= ~turn_q;
                            state_q <= ST_PLAY;
                        end
                    end
                    ST_OVER: begin
                        // Board, cursor and winner hold until a clear.
                    end
                    default: state_q <= ST_PLAY;
                endcase
            end
        end
    end

    assign turn        = turn_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign write_valid = write_valid_q;
    assign place_err   = place_err_q;

endmodule

// File: tb/tb_board_writer.sv
`timescale 1ns/1ps
module tb_board_writer;

    localparam logic [3:0] B_RIGHT = 4'b0001;
    localparam logic [3:0] B_DOWN  = 4'b0010;
    localparam logic [3:0] B_PLACE = 4'b0100;
    localparam logic [3:0] B_CLEAR = 4'b1000;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_down  = 1'b0;
    logic       btn_place = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] read_addr = 4'd0;
    logic [1:0] read_data;
    logic [3:0] cursor_addr;
    logic [9:0] cursor_posx;
    logic [9:0] cursor_posy;
    logic       turn;
    logic       game_over;
    logic [1:0] winner;
    logic       write_valid;
    logic       place_err;

    int checks    = 0;
    int failures  = 0;
    int wv_count  = 0;
    int err_count = 0;
    int tb_row    = 0;
    int tb_col    = 0;

    board_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_right   (btn_right),
        .btn_down    (btn_down),
        .btn_place   (btn_place),
        .btn_clear   (btn_clear),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .cursor_addr (cursor_addr),
        .cursor_posx (cursor_posx),
        .cursor_posy (cursor_posy),
        .turn        (turn),
        .game_over   (game_over),
        .winner      (winner),
        .write_valid (write_valid),
        .place_err   (place_err)
    );

    always #5 clk = ~clk;

    // Pulse counters: a pulse held longer than one cycle counts more than once.
    always @(negedge clk) begin
        if (write_valid === 1'b1) wv_count++;
        if (place_err === 1'b1)   err_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Press: hold 4 cycles (covers sync + action + CHECK), release 4 cycles.
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        {btn_clear, btn_place, btn_down, btn_right} = m;
        repeat (4) @(negedge clk);
        {btn_clear, btn_place, btn_down, btn_right} = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_clear();
        press(B_CLEAR);
        tb_row = 0;
        tb_col = 0;
    endtask

    task automatic goto_cell(input int target);
        while (tb_col != target % 3) begin
            press(B_RIGHT);
            tb_col = (tb_col + 1) % 3;
        end
        while (tb_row != target / 3) begin
            press(B_DOWN);
            tb_row = (tb_row + 1) % 3;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cursor_addr !== 4'd0) begin failures++; $display("FAIL reset_cursor_addr got=%0d exp=0", cursor_addr); end
        checks++; if (cursor_posx !== 10'd73) begin failures++; $display("FAIL reset_posx got=%0d exp=73", cursor_posx); end
        checks++; if (cursor_posy !== 10'd47) begin failures++; $display("FAIL reset_posy got=%0d exp=47", cursor_posy); end
        checks++; if (turn !== 1'b0) begin failures++; $display("FAIL reset_turn got=%b exp=0", turn); end
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
        checks++; if (winner !== 2'b00) begin failures++; $display("FAIL reset_winner got=%b exp=00", winner); end
        checks++; if (write_valid !== 1'b0) begin failures++; $display("FAIL reset_write_valid got=%b exp=0", write_valid); end
        checks++; if (place_err !== 1'b0) begin failures++; $display("FAIL reset_place_err got=%b exp=0", place_err); end
        for (int a = 0; a < 16; a++) begin
            read_addr = 4'(a);
            #1;
            checks++; if (read_data !== 2'b00) begin failures++; $display("FAIL reset_read_data addr=%0d got=%b exp=00", a, read_data); end
        end
        rst_n = 1'b1;
        tb_row = 0;
        tb_col = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cursor();
        logic [3:0] exp_addr [3];
        logic [9:0] exp_x    [3];
        exp_addr = '{4'd1, 4'd2, 4'd0};
        exp_x    = '{10'd283, 10'd493, 10'd73};
        for (int i = 0; i < 3; i++) begin
            press(B_RIGHT);
            checks++; if (cursor_addr !== exp_addr[i]) begin failures++; $display("FAIL right_addr step=%0d got=%0d exp=%0d", i, cursor_addr, exp_addr[i]); end
            checks++; if (cursor_posx !== exp_x[i]) begin failures++; $display("FAIL right_posx step=%0d got=%0d exp=%0d", i, cursor_posx, exp_x[i]); end
            checks++; if (cursor_posy !== 10'd47) begin failures++; $display("FAIL right_posy step=%0d got=%0d exp=47", i, cursor_posy); end
        end
        press(B_RIGHT | B_DOWN);
        checks++; if (cursor_addr !== 4'd4) begin failures++; $display("FAIL diag_addr got=%0d exp=4", cursor_addr); end
        checks++; if (cursor_posx !== 10'd283) begin failures++; $display("FAIL diag_posx got=%0d exp=283", cursor_posx); end
        checks++; if (cursor_posy !== 10'd205) begin failures++; $display("FAIL diag_posy got=%0d exp=205", cursor_posy); end
        press(B_DOWN);
        checks++; if (cursor_addr !== 4'd7) begin failures++; $display("FAIL down_addr got=%0d exp=7", cursor_addr); end
        checks++; if (cursor_posy !== 10'd363) begin failures++; $display("FAIL down_posy got=%0d exp=363", cursor_posy); end
        press(B_DOWN);
        checks++; if (cursor_addr !== 4'd1) begin failures++; $display("FAIL wrap_addr got=%0d exp=1", cursor_addr); end
        checks++; if (cursor_posy !== 10'd47) begin failures++; $display("FAIL wrap_posy got=%0d exp=47", cursor_posy); end
        do_clear();
        checks++; if (cursor_addr !== 4'd0) begin failures++; $display("FAIL clear_cursor got=%0d exp=0", cursor_addr); end
    endtask

    task automatic test_place();
        int w0;
        int e0;
        do_clear();
        read_addr = 4'd0;
        @(negedge clk);
        btn_place = 1'b1;
        @(negedge clk);  // after edge k
        checks++; if (write_valid !== 1'b0) begin failures++; $display("FAIL lat_k_wv got=%b exp=0", write_valid); end
        @(negedge clk);  // after edge k+1
        checks++; if (write_valid !== 1'b0) begin failures++; $display("FAIL lat_k1_wv got=%b exp=0", write_valid); end
        checks++; if (read_data !== 2'b00) begin failures++; $display("FAIL lat_k1_data got=%b exp=00", read_data); end
        @(negedge clk);  // after edge k+2
        checks++; if (write_valid !== 1'b1) begin failures++; $display("FAIL lat_k2_wv got=%b exp=1", write_valid); end
        checks++; if (read_data !== 2'b01) begin failures++; $display("FAIL lat_k2_data got=%b exp=01", read_data); end
        checks++; if (turn !== 1'b0) begin failures++; $display("FAIL lat_k2_turn got=%b exp=0", turn); end
        @(negedge clk);  // after edge k+3
        checks++; if (write_valid !== 1'b0) begin failures++; $display("FAIL lat_k3_wv got=%b exp=0", write_valid); end
        checks++; if (turn !== 1'b1) begin failures++; $display("FAIL lat_k3_turn got=%b exp=1", turn); end
        btn_place = 1'b0;
        repeat (4) @(negedge clk);

        w0 = wv_count;
        e0 = err_count;
        press(B_PLACE);
        checks++; if (err_count - e0 !== 1) begin failures++; $display("FAIL occupied_err pulses got=%0d exp=1", err_count - e0); end
        checks++; if (wv_count - w0 !== 0) begin failures++; $display("FAIL occupied_wv pulses got=%0d exp=0", wv_count - w0); end
        checks++; if (turn !== 1'b1) begin failures++; $display("FAIL occupied_turn got=%b exp=1", turn); end
        checks++; if (read_data !== 2'b01) begin failures++; $display("FAIL occupied_data got=%b exp=01", read_data); end
    endtask

    task automatic test_same_cycle();
        int w0;
        do_clear();
        w0 = wv_count;
        press(B_PLACE | B_RIGHT);
        checks++; if (wv_count - w0 !== 1) begin failures++; $display("FAIL pm_wv pulses got=%0d exp=1", wv_count - w0); end
        checks++; if (cursor_addr !== 4'd0) begin failures++; $display("FAIL pm_cursor got=%0d exp=0", cursor_addr); end
        read_addr = 4'd0; #1;
        checks++; if (read_data !== 2'b01) begin failures++; $display("FAIL pm_cell0 got=%b exp=01", read_data); end
        read_addr = 4'd1; #1;
        checks++; if (read_data !== 2'b00) begin failures++; $display("FAIL pm_cell1 got=%b exp=00", read_data); end
        // Clear outranks a simultaneous place.
        w0 = wv_count;
        press(B_CLEAR | B_PLACE);
        tb_row = 0;
        tb_col = 0;
        read_addr = 4'd0; #1;
        checks++; if (wv_count - w0 !== 0) begin failures++; $display("FAIL cp_wv pulses got=%0d exp=0", wv_count - w0); end
        checks++; if (read_data !== 2'b00) begin failures++; $display("FAIL cp_cell0 got=%b exp=00", read_data); end
        checks++; if (turn !== 1'b0) begin failures++; $display("FAIL cp_turn got=%b exp=0", turn); end
    endtask

    task automatic test_win();
        int cells [5];
        int w0;
        int e0;
        logic [1:0] mark;
        cells = '{0, 3, 1, 4, 2};
        do_clear();
        for (int i = 0; i < 5; i++) begin
            mark = (i % 2 == 0) ? 2'b01 : 2'b10;
            goto_cell(cells[i]);
            w0 = wv_count;
            press(B_PLACE);
            read_addr = 4'(cells[i]); #1;
            checks++; if (wv_count - w0 !== 1) begin failures++; $display("FAIL win_wv move=%0d got=%0d exp=1", i, wv_count - w0); end
            checks++; if (read_data !== mark) begin failures++; $display("FAIL win_data move=%0d got=%b exp=%b", i, read_data, mark); end
            if (i < 4) begin
                checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL win_early_over move=%0d got=%b exp=0", i, game_over); end
                checks++; if (turn !== 1'((i + 1) % 2)) begin failures++; $display("FAIL win_turn move=%0d got=%b exp=%0d", i, turn, (i + 1) % 2); end
            end
        end
        checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL win_over got=%b exp=1", game_over); end
        checks++; if (winner !== 2'b01) begin failures++; $display("FAIL win_winner got=%b exp=01", winner); end
        w0 = wv_count;
        e0 = err_count;
        press(B_PLACE);
        press(B_RIGHT);
        checks++; if (wv_count - w0 !== 0) begin failures++; $display("FAIL over_place_wv got=%0d exp=0", wv_count - w0); end
        checks++; if (err_count - e0 !== 0) begin failures++; $display("FAIL over_place_err got=%0d exp=0", err_count - e0); end
        checks++; if (cursor_addr !== 4'd2) begin failures++; $display("FAIL over_cursor got=%0d exp=2", cursor_addr); end
        checks++; if (winner !== 2'b01) begin failures++; $display("FAIL over_winner_hold got=%b exp=01", winner); end
        do_clear();
        for (int a = 0; a < 9; a++) begin
            read_addr = 4'(a); #1;
            checks++; if (read_data !== 2'b00) begin failures++; $display("FAIL clr_board addr=%0d got=%b exp=00", a, read_data); end
        end
        checks++; if (turn !== 1'b0) begin failures++; $display("FAIL clr_turn got=%b exp=0", turn); end
        checks++; if (cursor_addr !== 4'd0) begin failures++; $display("FAIL clr_cursor got=%0d exp=0", cursor_addr); end
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL clr_over got=%b exp=0", game_over); end
        checks++; if (winner !== 2'b00) begin failures++; $display("FAIL clr_winner got=%b exp=00", winner); end
    endtask

    task automatic test_draw();
        // Final board: X O X / X O O / O X X -- no line for either player.
        int cells [9];
        int w0;
        logic [1:0] mark;
        cells = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        do_clear();
        for (int i = 0; i < 9; i++) begin
            mark = (i % 2 == 0) ? 2'b01 : 2'b10;
            goto_cell(cells[i]);
            w0 = wv_count;
            press(B_PLACE);
            read_addr = 4'(cells[i]); #1;
            checks++; if (wv_count - w0 !== 1) begin failures++; $display("FAIL draw_wv move=%0d got=%0d exp=1", i, wv_count - w0); end
            checks++; if (read_data !== mark) begin failures++; $display("FAIL draw_data move=%0d got=%b exp=%b", i, read_data, mark); end
            if (i < 8) begin
                checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL draw_early_over move=%0d got=%b exp=0", i, game_over); end
            end
        end
        checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL draw_over got=%b exp=1", game_over); end
        checks++; if (winner !== 2'b00) begin failures++; $display("FAIL draw_winner got=%b exp=00", winner); end
        for (int a = 9; a < 16; a++) begin
            read_addr = 4'(a); #1;
            checks++; if (read_data !== 2'b00) begin failures++; $display("FAIL oob_read addr=%0d got=%b exp=00", a, read_data); end
        end
        do_clear();
    endtask

    task automatic test_hold();
        int w0;
        int e0;
        do_clear();
        w0 = wv_count;
        e0 = err_count;
        @(negedge clk);
        btn_place = 1'b1;
        repeat (100) @(negedge clk);
        btn_place = 1'b0;
        repeat (6) @(negedge clk);
        read_addr = 4'd0; #1;
        checks++; if (wv_count - w0 !== 1) begin failures++; $display("FAIL hold_wv pulses got=%0d exp=1", wv_count - w0); end
        checks++; if (err_count - e0 !== 0) begin failures++; $display("FAIL hold_err pulses got=%0d exp=0", err_count - e0); end
        checks++; if (read_data !== 2'b01) begin failures++; $display("FAIL hold_data got=%b exp=01", read_data); end
    endtask

    task automatic test_reset_mid();
        int w0;
        do_clear();
        read_addr = 4'd0;
        // Reset while a place edge is still in the synchronizer.
        w0 = wv_count;
        @(negedge clk);
        btn_place = 1'b1;
        repeat (2) @(negedge clk);  // after edge k+1
        rst_n = 1'b0;
        #1;
        btn_place = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (wv_count - w0 !== 0) begin failures++; $display("FAIL rst_pending_wv got=%0d exp=0", wv_count - w0); end
        checks++; if (read_data !== 2'b00) begin failures++; $display("FAIL rst_pending_data got=%b exp=00", read_data); end
        // Reset while the FSM is in CHECK.
        @(negedge clk);
        btn_place = 1'b1;
        repeat (3) @(negedge clk);  // after edge k+2: write done, in CHECK
        rst_n = 1'b0;
        #1;
        btn_place = 1'b0;
        checks++; if (read_data !== 2'b00) begin failures++; $display("FAIL rst_check_data got=%b exp=00", read_data); end
        checks++; if (write_valid !== 1'b0) begin failures++; $display("FAIL rst_check_wv got=%b exp=0", write_valid); end
        checks++; if (turn !== 1'b0) begin failures++; $display("FAIL rst_check_turn got=%b exp=0", turn); end
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL rst_check_over got=%b exp=0", game_over); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (turn !== 1'b0) begin failures++; $display("FAIL rst_check_turn_after got=%b exp=0", turn); end
        tb_row = 0;
        tb_col = 0;
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_place();
        test_same_cycle();
        test_win();
        test_draw();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
